decode_regbank: RTL and testbench
=================================

DECODE_REGBANK -- requirements
Module: decode_regbank

Interface
REQ-001 Parameter DATA_W, 32, register and operand width.
REQ-002 Parameter ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter IMM_W, 16, immediate field width; IMM_W < DATA_W.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  reset; synchronous, active-high.
REQ-006 DEC_EN  in  1  decode request for the current operand set.
REQ-007 DIR_A, DIR_B  in  ADDR_W  source register addresses.
REQ-008 DIR_DST  in  ADDR_W  destination register of the instruction being decoded.
REQ-009 DST_VAL  in  1  the decoded instruction writes DIR_DST.
REQ-010 IMD  in  IMM_W  raw immediate field.
REQ-011 EXT_MODE  in  2  00 sign-extend, 01 zero-extend, 10 upper (IMD placed in MSBs, low bits 0), 11 zero-extend.
REQ-012 REG_WR  in  1  writeback enable, active-high.
REQ-013 DIR_WRA  in  ADDR_W  writeback address.
REQ-014 DI  in  DATA_W  writeback data.
REQ-015 FLUSH  in  1  pipeline flush.
REQ-016 DOA, DOB  out  DATA_W  registered operands.
REQ-017 IMM_EXT  out  DATA_W  registered extended immediate.
REQ-018 OUT_VALID  out  1  DOA/DOB/IMM_EXT hold a newly accepted decode.
REQ-019 STALL  out  1  combinational; decode request cannot be accepted this cycle.

Function
REQ-020 Register 0 shall read as 0 always; writes to it shall be discarded.
REQ-021 When REG_WR=1 and DIR_WRA!=0, register[DIR_WRA] shall take DI at the clock edge.
REQ-022 A decode is accepted when DEC_EN=1, STALL=0, FLUSH=0, RST=0.
REQ-023 On acceptance, DOA/DOB/IMM_EXT shall update at the same edge (1-cycle latency) and OUT_VALID shall be 1 the following cycle; otherwise OUT_VALID=0 and DOA/DOB/IMM_EXT hold.
REQ-024 Bypass: if REG_WR=1, DIR_WRA!=0 and DIR_WRA equals a source address in the accepting cycle, that operand shall capture DI, not the stored value.
REQ-025 Scoreboard: one busy bit per register; busy[0] is constant 0.
REQ-026 Accepted decode with DST_VAL=1 and DIR_DST!=0 shall set busy[DIR_DST].
REQ-027 REG_WR=1 shall clear busy[DIR_WRA]; if set and clear target the same register in one cycle, set wins.
REQ-028 STALL=1 when DEC_EN=1 and any of: DIR_A busy, DIR_B busy, (DST_VAL=1 and DIR_DST busy) -- except that a busy register being written back this cycle counts as not busy.
REQ-029 STALL shall be 0 when DEC_EN=0.
REQ-030 Writeback to a non-busy register shall be legal and leave busy unchanged.
REQ-031 FLUSH=1 shall clear all busy bits and OUT_VALID at the edge, reject any decode, preserve register contents, and still perform a concurrent writeback.
REQ-032 Priority: RST over FLUSH over normal operation.

Reset
REQ-033 RST=1 at an edge shall zero all registers, all busy bits, DOA, DOB, IMM_EXT and OUT_VALID, discarding any concurrent write or decode.
REQ-034 Reset asserted mid-stall shall leave STALL=0 on the first cycle after release with DEC_EN=1 and DST_VAL=0.

Structure
REQ-035 Package decode_pkg shall hold EXT_MODE encodings and parameter defaults.
REQ-036 Busy-bit tracking shall be sub-module reg_scoreboard (set/clear/flush/query ports); extension and array stay in decode_regbank.

Verification
REQ-037 Write r5=0x0000_00AA, then decode DIR_A=5, DIR_B=0 -> next cycle DOA=0x0000_00AA, DOB=0, OUT_VALID=1.
REQ-038 Same cycle REG_WR to r7 with DI=0x1234_5678 and decode DIR_A=7 -> DOA=0x1234_5678 (bypass).
REQ-039 IMD=0x8001, modes 00/01/10 -> IMM_EXT=0xFFFF_8001 / 0x0000_8001 / 0x8001_0000.
REQ-040 Decode DST=r3, then decode DIR_A=3 -> STALL=1 until REG_WR to r3, accepted in the writeback cycle with bypassed DI.
REQ-041 Busy r3 and r4, assert FLUSH -> next cycle decode of DIR_A=3, DIR_B=4 has STALL=0; register values intact.
REQ-042 Write r9, set busy r9, assert RST -> r9 reads 0, STALL=0, all outputs 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings and parameter defaults for the decode stage register bank.
package decode_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned IMM_W_DEF  = 16;

  typedef enum logic [1:0] {
    EXT_SIGN     = 2'b00,
    EXT_ZERO     = 2'b01,
    EXT_UPPER    = 2'b10,
    EXT_ZERO_ALT = 2'b11
  } ext_mode_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking: set on issue, clear on writeback, wiped on flush.
module reg_scoreboard
  import decode_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] qa_addr,
  input  logic [ADDR_W-1:0] qb_addr,
  input  logic [ADDR_W-1:0] qd_addr,
  output logic              qa_busy_c,
  output logic              qb_busy_c,
  output logic              qd_busy_c
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear first so a same-register set in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) busy_q <= '0;
    else              busy_q <= busy_d;
  end

  // A register being written back this cycle is already resolved.
  assign qa_busy_c = busy_q[qa_addr] & ~(clr_en & (clr_addr == qa_addr));
  assign qb_busy_c = busy_q[qb_addr] & ~(clr_en & (clr_addr == qb_addr));
  assign qd_busy_c = busy_q[qd_addr] & ~(clr_en & (clr_addr == qd_addr));

endmodule

// File: rtl/decode_regbank.sv
// Decode-stage register file with writeback bypass, immediate extension and
// scoreboard-based hazard stall.
module decode_regbank
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned IMM_W  = IMM_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DEC_EN,
  input  logic [ADDR_W-1:0] DIR_A,
  input  logic [ADDR_W-1:0] DIR_B,
  input  logic [ADDR_W-1:0] DIR_DST,
  input  logic              DST_VAL,
  input  logic [IMM_W-1:0]  IMD,
  input  logic [1:0]        EXT_MODE,
  input  logic              REG_WR,
  input  logic [ADDR_W-1:0] DIR_WRA,
  input  logic [DATA_W-1:0] DI,
  input  logic              FLUSH,
  output logic [DATA_W-1:0] DOA,
  output logic [DATA_W-1:0] DOB,
  output logic [DATA_W-1:0] IMM_EXT,
  output logic              OUT_VALID,
  output logic              STALL
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned PAD_W    = DATA_W - IMM_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en;
  logic              accept;
  logic              a_busy, b_busy, d_busy;
  logic [DATA_W-1:0] rd_a, rd_b, imm_val;

  assign wr_en  = REG_WR && (DIR_WRA != '0);
  assign STALL  = DEC_EN && (a_busy || b_busy || (DST_VAL && d_busy));
  assign accept = DEC_EN && !STALL && !FLUSH && !RST;

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk       (CLK),
    .rst       (RST),
    .flush     (FLUSH),
    .set_en    (accept && DST_VAL && (DIR_DST != '0)),
    .set_addr  (DIR_DST),
    .clr_en    (REG_WR),
    .clr_addr  (DIR_WRA),
    .qa_addr   (DIR_A),
    .qb_addr   (DIR_B),
    .qd_addr   (DIR_DST),
    .qa_busy_c (a_busy),
    .qb_busy_c (b_busy),
    .qd_busy_c (d_busy)
  );

  // Register 0 is never written, so it reads as zero after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[DIR_WRA] <= DI;
    end
  end

  // Same-cycle writeback data overrides the stored value.
  assign rd_a = (wr_en && (DIR_WRA == DIR_A)) ? DI : regs_q[DIR_A];
  assign rd_b = (wr_en && (DIR_WRA == DIR_B)) ? DI : regs_q[DIR_B];

  always_comb begin
    imm_val = '0;
    case (ext_mode_e'(EXT_MODE))
      EXT_SIGN:  imm_val = {{PAD_W{IMD[IMM_W-1]}}, IMD};
      EXT_UPPER: imm_val = {IMD, {PAD_W{1'b0}}};
      default:   imm_val = {{PAD_W{1'b0}}, IMD};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DOA       <= '0;
      DOB       <= '0;
      IMM_EXT   <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= accept;
      if (accept) begin
        DOA     <= rd_a;
        DOB     <= rd_b;
        IMM_EXT <= imm_val;
      end
    end
  end

endmodule

// File: tb/tb_decode_regbank.sv
// Directed vector bench for decode_regbank: operand read, bypass, immediate
// extension, scoreboard stall, flush and reset behaviour.
module tb_decode_regbank;

  logic        CLK = 1'b0;
  logic        RST, DEC_EN, DST_VAL, REG_WR, FLUSH;
  logic [4:0]  DIR_A, DIR_B, DIR_DST, DIR_WRA;
  logic [15:0] IMD;
  logic [1:0]  EXT_MODE;
  logic [31:0] DI, DOA, DOB, IMM_EXT;
  logic        OUT_VALID, STALL;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  decode_regbank dut (
    .CLK(CLK), .RST(RST), .DEC_EN(DEC_EN), .DIR_A(DIR_A), .DIR_B(DIR_B),
    .DIR_DST(DIR_DST), .DST_VAL(DST_VAL), .IMD(IMD), .EXT_MODE(EXT_MODE),
    .REG_WR(REG_WR), .DIR_WRA(DIR_WRA), .DI(DI), .FLUSH(FLUSH),
    .DOA(DOA), .DOB(DOB), .IMM_EXT(IMM_EXT), .OUT_VALID(OUT_VALID), .STALL(STALL)
  );

  typedef struct {
    logic        rst, de;
    logic [4:0]  a, b, dst;
    logic        dv;
    logic [15:0] imd;
    logic [1:0]  mode;
    logic        wr;
    logic [4:0]  wra;
    logic [31:0] di;
    logic        fl;
    logic        stall, ov;
    logic [31:0] doa, dob, imm;
  } vec_t;

  function automatic vec_t mk(
      input logic rst, de, input logic [4:0] a, b, dst, input logic dv,
      input logic [15:0] imd, input logic [1:0] mode, input logic wr,
      input logic [4:0] wra, input logic [31:0] di, input logic fl,
      input logic stall, ov, input logic [31:0] doa, dob, imm);
    vec_t v;
    v.rst = rst; v.de = de; v.a = a; v.b = b; v.dst = dst; v.dv = dv;
    v.imd = imd; v.mode = mode; v.wr = wr; v.wra = wra; v.di = di; v.fl = fl;
    v.stall = stall; v.ov = ov; v.doa = doa; v.dob = dob; v.imm = imm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    RST = v.rst; DEC_EN = v.de; DIR_A = v.a; DIR_B = v.b; DIR_DST = v.dst;
    DST_VAL = v.dv; IMD = v.imd; EXT_MODE = v.mode; REG_WR = v.wr;
    DIR_WRA = v.wra; DI = v.di; FLUSH = v.fl;
  endtask

  // Stall is checked before the edge, registered outputs just after it.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    chk({tag, ".stall"}, 32'(STALL), 32'(v.stall));
    @(posedge CLK);
    #1;
    chk({tag, ".valid"}, 32'(OUT_VALID), 32'(v.ov));
    chk({tag, ".doa"}, DOA, v.doa);
    chk({tag, ".dob"}, DOB, v.dob);
    chk({tag, ".imm"}, IMM_EXT, v.imm);
  endtask

  vec_t tbl[29];

  initial begin
    //          rst de a  b  dst dv imd      md wr wra di            fl  stall ov doa           dob     imm
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  0, 0, 32'h0,         32'h0,  32'h0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 16'h0,    0, 1, 5, 32'hAA,        0,  0, 0, 32'h0,         32'h0,  32'h0);
    tbl[2]  = mk(0, 1, 5, 0, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  0, 1, 32'hAA,        32'h0,  32'h0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  0, 0, 32'hAA,        32'h0,  32'h0);
    tbl[4]  = mk(0, 1, 7, 5, 0, 0, 16'h0,    0, 1, 7, 32'h1234_5678, 0,  0, 1, 32'h1234_5678, 32'hAA, 32'h0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 16'h8001, 0, 0, 0, 32'h0,         0,  0, 1, 32'h0,         32'h0,  32'hFFFF_8001);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 16'h8001, 1, 0, 0, 32'h0,         0,  0, 1, 32'h0,         32'h0,  32'h0000_8001);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 16'h8001, 2, 0, 0, 32'h0,         0,  0, 1, 32'h0,         32'h0,  32'h8001_0000);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 16'h8001, 3, 0, 0, 32'h0,         0,  0, 1, 32'h0,         32'h0,  32'h0000_8001);
    tbl[9]  = mk(0, 1, 0, 0, 3, 1, 16'h0,    0, 0, 0, 32'h0,         0,  0, 1, 32'h0,         32'h0,  32'h0);
    tbl[10] = mk(0, 1, 3, 0, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  1, 0, 32'h0,         32'h0,  32'h0);
    tbl[11] = mk(0, 1, 3, 0, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  1, 0, 32'h0,         32'h0,  32'h0);
    tbl[12] = mk(0, 1, 3, 0, 0, 0, 16'h0,    0, 1, 3, 32'hCAFE_0003, 0,  0, 1, 32'hCAFE_0003, 32'h0,  32'h0);
    tbl[13] = mk(0, 1, 3, 0, 0, 0, 16'h0,    0, 1, 4, 32'h44,        0,  0, 1, 32'hCAFE_0003, 32'h0,  32'h0);
    tbl[14] = mk(0, 1, 0, 0, 4, 1, 16'h0,    0, 0, 0, 32'h0,         0,  0, 1, 32'h0,         32'h0,  32'h0);
    tbl[15] = mk(0, 1, 0, 0, 4, 1, 16'h0,    0, 0, 0, 32'h0,         0,  1, 0, 32'h0,         32'h0,  32'h0);
    tbl[16] = mk(0, 1, 0, 0, 3, 1, 16'h0,    0, 0, 0, 32'h0,         0,  0, 1, 32'h0,         32'h0,  32'h0);
    tbl[17] = mk(0, 1, 5, 0, 0, 0, 16'h0,    0, 1, 9, 32'h99,        1,  0, 0, 32'h0,         32'h0,  32'h0);
    tbl[18] = mk(0, 1, 3, 4, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  0, 1, 32'hCAFE_0003, 32'h44, 32'h0);
    tbl[19] = mk(0, 1, 9, 0, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  0, 1, 32'h99,        32'h0,  32'h0);
    tbl[20] = mk(0, 1, 0, 0, 6, 1, 16'h0,    0, 1, 6, 32'h66,        0,  0, 1, 32'h0,         32'h0,  32'h0);
    tbl[21] = mk(0, 1, 6, 0, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  1, 0, 32'h0,         32'h0,  32'h0);
    tbl[22] = mk(0, 1, 0, 0, 0, 0, 16'h0,    0, 1, 0, 32'hFFFF_FFFF, 0,  0, 1, 32'h0,         32'h0,  32'h0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 16'h0,    0, 1, 6, 32'h6006,      0,  0, 0, 32'h0,         32'h0,  32'h0);
    tbl[24] = mk(0, 1, 6, 5, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  0, 1, 32'h6006,      32'hAA, 32'h0);
    tbl[25] = mk(0, 1, 9, 5, 9, 1, 16'h7FFF, 0, 0, 0, 32'h0,         0,  0, 1, 32'h99,        32'hAA, 32'h0000_7FFF);
    tbl[26] = mk(0, 1, 9, 0, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  1, 0, 32'h99,        32'hAA, 32'h0000_7FFF);
    tbl[27] = mk(1, 1, 0, 0, 0, 0, 16'h0,    0, 1, 2, 32'h22,        0,  0, 0, 32'h0,         32'h0,  32'h0);
    tbl[28] = mk(0, 1, 9, 2, 0, 0, 16'h0,    0, 0, 0, 32'h0,         0,  0, 1, 32'h0,         32'h0,  32'h0);

    for (int i = 0; i < 29; i++) apply(tbl[i], $sformatf("v%0d", i));

    // Multi-cycle hazard: r10 stays busy across several cycles until writeback.
    apply(mk(0, 1, 0, 0, 10, 1, 16'h0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h0, 32'h0), "seq.issue");
    for (int k = 0; k < 3; k++)
      apply(mk(0, 1, 10, 0, 0, 0, 16'h0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 32'h0),
            $sformatf("seq.wait%0d", k));
    apply(mk(0, 1, 10, 10, 0, 0, 16'h0, 0, 1, 10, 32'hA5A5_0010, 0,
             0, 1, 32'hA5A5_0010, 32'hA5A5_0010, 32'h0), "seq.wb");
    apply(mk(0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 32'h0, 0,
             0, 0, 32'hA5A5_0010, 32'hA5A5_0010, 32'h0), "seq.idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
